// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - ALU result, load result and register-file write port bundle
interface writeback_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_raw;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic        alu_stall;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_enable;
    logic [1:0]  fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output ld_valid, ld_rd, ld_raw, ld_funct3, ld_byte_off,
        input  ld_ready, alu_stall, rd_addr, rd_data, wr_enable, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  ld_valid, ld_rd, ld_raw, ld_funct3, ld_byte_off,
        output ld_ready, alu_stall, rd_addr, rd_data, wr_enable, fifo_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - ALU-priority writeback arbiter with a 2-entry formatted load buffer
module writeback_arbiter (
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.slave  wb
);
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [4:0]  ent_rd_q   [2];
    logic [4:0]  ent_rd_d   [2];
    logic [31:0] ent_data_q [2];
    logic [31:0] ent_data_d [2];
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        wr_enable_q, wr_enable_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic        enq;
    logic        deq;

    always_comb begin
        case (wb.ld_byte_off)
            2'd0:    ld_byte = wb.ld_raw[7:0];
            2'd1:    ld_byte = wb.ld_raw[15:8];
            2'd2:    ld_byte = wb.ld_raw[23:16];
            default: ld_byte = wb.ld_raw[31:24];
        endcase
        ld_half = wb.ld_byte_off[1] ? wb.ld_raw[31:16] : wb.ld_raw[15:0];
        case (wb.ld_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = wb.ld_raw;
        endcase
    end

    // Both decisions look only at registered occupancy, so a load enqueued
    // this cycle cannot be dequeued before the next one.
    assign enq = wb.ld_valid && (count_q != 2'd2);
    assign deq = !wb.alu_valid && (count_q != 2'd0);

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ent_rd_d    = ent_rd_q;
        ent_data_d  = ent_data_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        wr_enable_d = 1'b0;

        if (enq) begin
            ent_rd_d[wr_ptr_q]   = wb.ld_rd;
            ent_data_d[wr_ptr_q] = ld_fmt;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (wb.alu_valid) begin
            rd_addr_d   = wb.alu_rd;
            rd_data_d   = wb.alu_result;
            wr_enable_d = (wb.alu_rd != 5'd0);
        end else if (deq) begin
            rd_addr_d   = ent_rd_q[rd_ptr_q];
            rd_data_d   = ent_data_q[rd_ptr_q];
            wr_enable_d = (ent_rd_q[rd_ptr_q] != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            rd_addr_q   <= 5'd0;
            rd_data_q   <= 32'd0;
            wr_enable_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            wr_enable_q <= wr_enable_d;
        end
    end

    // Entry storage is only meaningful under the count, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_rd_q   <= ent_rd_d;
        ent_data_q <= ent_data_d;
    end

    assign wb.ld_ready   = (count_q != 2'd2);
    assign wb.alu_stall  = (count_q == 2'd2);
    assign wb.fifo_count = count_q;
    assign wb.rd_addr    = rd_addr_q;
    assign wb.rd_data    = rd_data_q;
    assign wb.wr_enable  = wr_enable_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized checks of writeback_arbiter against a queue model
module tb_writeback_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_arbiter_if wb();
    writeback_arbiter dut (.clk(clk), .reset(reset), .wb(wb.slave));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] fmt(logic [31:0] raw, logic [2:0] f3, logic [1:0] off);
        int unsigned b;
        int unsigned h;
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit av, bit [4:0] ard, bit [31:0] ares,
                         bit lv, bit [4:0] lrd, bit [31:0] lraw, bit [2:0] lf3, bit [1:0] loff);
        wb.alu_valid   = av;
        wb.alu_rd      = ard;
        wb.alu_result  = ares;
        wb.ld_valid    = lv;
        wb.ld_rd       = lrd;
        wb.ld_raw      = lraw;
        wb.ld_funct3   = lf3;
        wb.ld_byte_off = loff;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all(string tag);
        check({tag, ".wr_enable"},  {31'd0, wb.wr_enable},  {31'd0, m_we});
        check({tag, ".rd_addr"},    {27'd0, wb.rd_addr},    {27'd0, m_addr});
        check({tag, ".rd_data"},    wb.rd_data,             m_data);
        check({tag, ".fifo_count"}, {30'd0, wb.fifo_count}, q.size());
        check({tag, ".ld_ready"},   {31'd0, wb.ld_ready},   (q.size() < 2) ? 32'd1 : 32'd0);
        check({tag, ".alu_stall"},  {31'd0, wb.alu_stall},  (q.size() == 2) ? 32'd1 : 32'd0);
    endtask

    // Predict the effect of the coming edge from the current inputs, then sample after it.
    task automatic step(string tag);
        bit   acc;
        ent_t e;
        acc = wb.ld_valid && (q.size() < 2);
        if (wb.alu_valid) begin
            m_addr = wb.alu_rd;
            m_data = wb.alu_result;
            m_we   = (wb.alu_rd != 0);
        end else if (q.size() > 0) begin
            e      = q.pop_front();
            m_addr = e.rd;
            m_data = e.data;
            m_we   = (e.rd != 0);
        end else begin
            m_we = 1'b0;
        end
        if (acc) begin
            e.rd   = wb.ld_rd;
            e.data = fmt(wb.ld_raw, wb.ld_funct3, wb.ld_byte_off);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = 0;
        m_data = 0;
        m_we   = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        idle();
        reset = 1'b1;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        drive(1, 5, 32'h12345678, 0, 0, 0, 0, 0);
        step("alu");
        check("alu.we_const",   {31'd0, wb.wr_enable}, 32'd1);
        check("alu.data_const", wb.rd_data, 32'h12345678);
        idle();
        step("alu_idle");

        drive(0, 0, 0, 1, 7, 32'h80FF_0000, 3'b000, 2'd3);
        step("lb_enq");
        check("lb_enq.we_const", {31'd0, wb.wr_enable}, 32'd0);
        idle();
        step("lb_out");
        check("lb.data_const", wb.rd_data, 32'hFFFFFF80);
        drive(0, 0, 0, 1, 7, 32'h80FF_0000, 3'b100, 2'd3);
        step("lbu_enq");
        idle();
        step("lbu_out");
        check("lbu.data_const", wb.rd_data, 32'h00000080);

        drive(1, 9, 32'hAAAA0001, 1, 1, 32'h1111_1111, 3'b010, 2'd0);
        step("full1");
        drive(1, 10, 32'hAAAA0002, 1, 2, 32'h2222_2222, 3'b010, 2'd0);
        step("full2");
        drive(1, 11, 32'hAAAA0003, 1, 3, 32'h3333_3333, 3'b010, 2'd0);
        step("full_stall_alu");
        check("full.count_const", {30'd0, wb.fifo_count}, 32'd2);
        check("full.stall_const", {31'd0, wb.alu_stall}, 32'd1);
        idle();
        step("drain1");
        check("drain1.rd_const", {27'd0, wb.rd_addr}, 32'd1);
        step("drain2");
        check("drain2.rd_const", {27'd0, wb.rd_addr}, 32'd2);
        step("drain_idle");

        drive(1, 0, 32'hFFFFFFFF, 1, 0, 32'h5555_AAAA, 3'b010, 2'd0);
        step("x0_alu");
        idle();
        step("x0_load");
        check("x0.count_const", {30'd0, wb.fifo_count}, 32'd0);
        check("x0.we_const", {31'd0, wb.wr_enable}, 32'd0);

        drive(1, 12, 32'h0BAD_0001, 1, 13, 32'hDEAD_BEEF, 3'b010, 2'd0);
        step("rst_fill1");
        drive(1, 12, 32'h0BAD_0002, 1, 14, 32'hCAFE_F00D, 3'b010, 2'd0);
        step("rst_fill2");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        idle();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("rst_after");
        end

        drive(0, 0, 0, 1, 20, 32'h8001_1234, 3'b001, 2'd2);
        step("lh_enq");
        idle();
        step("lh_out");
        check("lh.data_const", wb.rd_data, 32'hFFFF8001);
        drive(0, 0, 0, 1, 21, 32'h8001_1234, 3'b101, 2'd2);
        step("lhu_enq");
        idle();
        step("lhu_out");
        check("lhu.data_const", wb.rd_data, 32'h00008001);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                  3'($urandom), 2'($urandom));
            step("rand");
        end
        idle();
        step("final1");
        step("final2");
        step("final3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port alu_valid  input  1  ALU result present this cycle.
REQ-004 SHALL have port alu_rd  input  5  ALU destination register.
REQ-005 SHALL have port alu_result  input  32  ALU result value.
REQ-006 SHALL have port ld_valid  input  1  load result offered.
REQ-007 SHALL have port ld_ready  output  1  load accepted when ld_valid && ld_ready at edge.
REQ-008 SHALL have port ld_rd  input  5  load destination register.
REQ-009 SHALL have port ld_raw  input  32  raw aligned memory word.
REQ-010 SHALL have port ld_funct3  input  3  load type.
REQ-011 SHALL have port ld_byte_off  input  2  byte offset within word.
REQ-012 SHALL have port alu_stall  output  1  upstream must not assert alu_valid while high.
REQ-013 SHALL have port rd_addr  output  5  register-file write address.
REQ-014 SHALL have port rd_data  output  32  register-file write data.
REQ-015 SHALL have port wr_enable  output  1  register-file write strobe.
REQ-016 SHALL have port fifo_count  output  2  load buffer occupancy, 0..2.

Function
REQ-017 SHALL buffer accepted loads in a 2-entry FIFO storing rd, formatted data.
REQ-018 SHALL drive ld_ready = (fifo_count < 2), from registered state only; no enqueue when full even if dequeuing that cycle.
REQ-019 SHALL format load data at enqueue: funct3 000 LB sign-extended byte at ld_byte_off; 001 LH sign-extended half at ld_byte_off[1]*16; 010 LW whole word; 100 LBU zero-extended byte; 101 LHU zero-extended half; 011/110/111 raw word unchanged.
REQ-020 SHALL register outputs: rd_addr/rd_data/wr_enable update at the edge after selection (1-cycle latency for ALU results).
REQ-021 SHALL give ALU priority: alu_valid -> next-edge output alu_rd/alu_result, wr_enable=1 unless alu_rd==0.
REQ-022 SHALL dequeue FIFO head only in cycles with alu_valid=0; output head rd/data, wr_enable=1 unless head rd==0 (entry still dequeued).
REQ-023 SHALL drive wr_enable=0 in cycles with neither source; rd_addr/rd_data hold last values.
REQ-024 SHALL make a loaded entry eligible for dequeue no earlier than the cycle after enqueue (minimum load latency 2 edges to wr_enable).
REQ-025 SHALL allow simultaneous enqueue and dequeue when count<2; count unchanged.
REQ-026 SHALL drive alu_stall = (fifo_count == 2), from registered state.
REQ-027 SHALL, if alu_valid is asserted while alu_stall, still write ALU result and keep FIFO contents intact (no loss).
REQ-028 SHALL preserve FIFO order; pointers wrap modulo 2.

Reset
REQ-029 SHALL on reset asynchronously clear fifo_count, pointers, rd_addr=0, rd_data=0, wr_enable=0; ld_ready=1, alu_stall=0.
REQ-030 SHALL discard all buffered loads on reset mid-operation; first edge after deassert behaves as from empty.

Verification
REQ-031 SHALL test: alu_valid, alu_rd=5, alu_result=0x12345678 -> next edge wr_enable=1, rd_addr=5, rd_data=0x12345678.
REQ-032 SHALL test: load funct3=000, off=3, raw=0x80FF_0000, rd=7, no ALU -> two edges later wr_enable=1, rd_addr=7, rd_data=0xFFFFFF80; same with funct3=100 -> 0x00000080.
REQ-033 SHALL test: two loads (rd=1, rd=2) with continuous alu_valid -> fifo_count=2, ld_ready=0, alu_stall=1; ALU bubble -> rd 1 written first, then rd 2.
REQ-034 SHALL test: alu_rd=0 result 0xFFFFFFFF and load rd=0 -> wr_enable never 1; load entry still drains, fifo_count returns 0.
REQ-035 SHALL test: reset asserted with fifo_count=2 -> immediately fifo_count=0, wr_enable=0, ld_ready=1; no buffered write appears after release.
REQ-036 SHALL test: funct3=001, off=2, raw=0x8001_1234 -> rd_data=0xFFFF8001; funct3=101 -> 0x00008001.
